// File: rtl/display_pkg.sv
// Shared widths and field indices for the multiplexed seven-segment display path.
package display_pkg;
  localparam int PHASE_W    = 3;
  localparam int NUM_PHASES = 8;
  localparam int FIELD_W    = 6;
  localparam int DATA_W     = 12;
  localparam int FIELD_LO   = 0;
  localparam int FIELD_HI   = 1;

  typedef logic [PHASE_W-1:0] phase_t;

  // Digits 0,1 belong to the low field, digits 2,3 to the high field.
  function automatic logic field_of(input phase_t phase);
    return (phase[PHASE_W-1:1] >= 2'd2) ? 1'(FIELD_HI) : 1'(FIELD_LO);
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider that emits a one-cycle tick every PRESCALE enabled clocks.
module scan_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Scan phase sequencer with frame-aligned display value commit and per-field blink.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_data,
  output logic              upd_ready,
  input  logic [1:0]        blink_en,
  output logic [PHASE_W-1:0] byte_status,
  output logic [DATA_W-1:0] data_show,
  output logic              blank,
  output logic              frame_start
);
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam phase_t LAST_PHASE = phase_t'(NUM_PHASES - 1);

  logic              tick;
  logic              wrap;
  logic              accept;
  logic              pending;
  logic [DATA_W-1:0] shadow;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink_phase;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // Handshake: a transfer happens on any clock edge where upd_valid && upd_ready;
  // the producer holds upd_data stable while upd_valid is high and upd_ready is low.
  assign upd_ready = !pending;
  assign accept    = upd_valid && upd_ready;
  assign wrap      = tick && (byte_status == LAST_PHASE);
  assign blank     = !enable || (blink_phase && blink_en[field_of(byte_status)]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_status <= '0;
      data_show   <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        byte_status <= byte_status + 1'b1;
      end
      // Commit needs pending=1 and accept needs pending=0, so a value taken
      // on the wrap tick itself waits for the following wrap.
      if (wrap && pending) begin
        data_show <= shadow;
        pending   <= 1'b0;
      end else if (accept) begin
        shadow  <= upd_data;
        pending <= 1'b1;
      end
      if (wrap) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule
